// File: rtl/dataflow_pkg.sv
// rtl/dataflow_pkg.sv - shared width/depth defaults for the dataflow operand stages
// Also provides the occupancy-count width helper used by join_fifo and operand_join.
package dataflow_pkg;

  localparam int DF_WIDTH      = 16;
  localparam int DF_JOIN_DEPTH = 4;

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int join_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/join_fifo.sv
// rtl/join_fifo.sv - single-stream token FIFO, one per operand side of operand_join
// A push while full is dropped unless a pop in the same cycle frees the slot.
module join_fifo
  import dataflow_pkg::*;
#(
  parameter int W     = DF_WIDTH,
  parameter int DEPTH = DF_JOIN_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = join_cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/operand_join.sv
// rtl/operand_join.sv - pairs two skewed operand token streams into simultaneous valids
// Optional sticky overflow flag under macro JOIN_OVF_FLAG_EN; OVF is tied low otherwise.
module operand_join
  import dataflow_pkg::*;
#(
  parameter int N     = DF_WIDTH,
  parameter int DEPTH = DF_JOIN_DEPTH,
  localparam int CW   = join_cnt_w(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         R_IN1,
  input  logic [N-1:0] D_IN1,
  input  logic         R_IN2,
  input  logic [N-1:0] D_IN2,
  output logic         R_OUT1,
  output logic [N-1:0] D_OUT1,
  output logic         R_OUT2,
  output logic [N-1:0] D_OUT2,
  output logic         OVF
);

  logic [N-1:0]  fifo_head_a, fifo_head_b;
  logic [CW-1:0] count_a, count_b;
  logic          full_a, full_b;
  logic          empty_a, empty_b;
  logic          avail_a, avail_b;
  logic [N-1:0]  head_a, head_b;
  logic          fire;
  logic          push_a, push_b;
  logic          pop_a, pop_b;

  logic          r_out_q, r_out_d;
  logic [N-1:0]  d_out1_q, d_out1_d;
  logic [N-1:0]  d_out2_q, d_out2_d;

  assign avail_a = !empty_a || R_IN1;
  assign avail_b = !empty_b || R_IN2;
  assign head_a  = empty_a ? D_IN1 : fifo_head_a;
  assign head_b  = empty_b ? D_IN2 : fifo_head_b;
  assign fire    = avail_a && avail_b;

  // An incoming token that bypasses an empty FIFO as the head is consumed, not stored.
  assign pop_a  = EN && fire && !empty_a;
  assign pop_b  = EN && fire && !empty_b;
  assign push_a = EN && R_IN1 && !(fire && empty_a);
  assign push_b = EN && R_IN2 && !(fire && empty_b);

  join_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_a),
    .pop_i   (pop_a),
    .data_i  (D_IN1),
    .head_o  (fifo_head_a),
    .count_o (count_a),
    .full_o  (full_a),
    .empty_o (empty_a)
  );

  join_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_b),
    .pop_i   (pop_b),
    .data_i  (D_IN2),
    .head_o  (fifo_head_b),
    .count_o (count_b),
    .full_o  (full_b),
    .empty_o (empty_b)
  );

  always_comb begin
    r_out_d  = r_out_q;
    d_out1_d = d_out1_q;
    d_out2_d = d_out2_q;
    if (EN) begin
      r_out_d = fire;
      if (fire) begin
        d_out1_d = head_a;
        d_out2_d = head_b;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out_q  <= 1'b0;
      d_out1_q <= '0;
      d_out2_q <= '0;
    end else begin
      r_out_q  <= r_out_d;
      d_out1_q <= d_out1_d;
      d_out2_q <= d_out2_d;
    end
  end

  assign R_OUT1 = r_out_q;
  assign R_OUT2 = r_out_q;
  assign D_OUT1 = d_out1_q;
  assign D_OUT2 = d_out2_q;

`ifdef JOIN_OVF_FLAG_EN
  logic drop_any;
  logic ovf_q, ovf_d;

  // A drop is a push into a full side that is not popping in the same cycle.
  assign drop_any = (push_a && full_a && !pop_a) || (push_b && full_b && !pop_b);
  assign ovf_d    = ovf_q || drop_any;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;

  logic unused_sig;
  assign unused_sig = ^{count_a, count_b};
`else
  assign OVF = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{count_a, count_b, full_a, full_b};
`endif

endmodule

// File: tb/tb_operand_join.sv
// tb/tb_operand_join.sv - directed self-checking bench for operand_join
// Expected OVF follows whether JOIN_OVF_FLAG_EN is defined for the build.
module tb_operand_join;

  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic         R_IN1, R_IN2;
  logic [N-1:0] D_IN1, D_IN2;
  logic         R_OUT1, R_OUT2;
  logic [N-1:0] D_OUT1, D_OUT2;
  logic         OVF;

  int checks = 0;
  int errors = 0;

`ifdef JOIN_OVF_FLAG_EN
  localparam logic OVF_AFTER_DROP = 1'b1;
`else
  localparam logic OVF_AFTER_DROP = 1'b0;
`endif

  always #5 CLK = ~CLK;

  operand_join #(.N(N), .DEPTH(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .R_IN1  (R_IN1),
    .D_IN1  (D_IN1),
    .R_IN2  (R_IN2),
    .D_IN2  (D_IN2),
    .R_OUT1 (R_OUT1),
    .D_OUT1 (D_OUT1),
    .R_OUT2 (R_OUT2),
    .D_OUT2 (D_OUT2),
    .OVF    (OVF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ra, input logic [N-1:0] da, input logic rb, input logic [N-1:0] db);
    R_IN1 = ra;
    D_IN1 = da;
    R_IN2 = rb;
    D_IN2 = db;
  endtask

  task automatic check_pair(input string tag, input logic [N-1:0] ea, input logic [N-1:0] eb);
    check({tag, "_r1"}, 32'(R_OUT1), 32'd1);
    check({tag, "_r2"}, 32'(R_OUT2), 32'd1);
    check({tag, "_d1"}, 32'(D_OUT1), 32'(ea));
    check({tag, "_d2"}, 32'(D_OUT2), 32'(eb));
  endtask

  initial begin
    RST = 1'b1;
    EN  = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    #12;
    check("rst_r1", 32'(R_OUT1), 32'd0);
    check("rst_r2", 32'(R_OUT2), 32'd0);
    check("rst_d1", 32'(D_OUT1), 32'd0);
    check("rst_d2", 32'(D_OUT2), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    check("rst_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd0);
    RST = 1'b0;
    tick();

    // Aligned pair
    drive(1'b1, 16'd100, 1'b1, 16'd7);
    tick();
    check_pair("aligned", 16'd100, 16'd7);
    check("aligned_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd0);
    check("aligned_cnt_b", 32'(dut.u_fifo_b.count_o), 32'd0);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("aligned_idle_r1", 32'(R_OUT1), 32'd0);
    check("aligned_idle_d1", 32'(D_OUT1), 32'd100);

    // Skew: A early, B three cycles late
    drive(1'b1, 16'd10, 1'b0, '0); tick(); check("skew_a0_r", 32'(R_OUT1), 32'd0);
    drive(1'b1, 16'd20, 1'b0, '0); tick(); check("skew_a1_r", 32'(R_OUT1), 32'd0);
    drive(1'b1, 16'd30, 1'b0, '0); tick(); check("skew_a2_r", 32'(R_OUT1), 32'd0);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    check("skew_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd3);
    check("skew_gap_r", 32'(R_OUT2), 32'd0);
    drive(1'b0, '0, 1'b1, 16'd1); tick(); check_pair("skew_p0", 16'd10, 16'd1);
    drive(1'b0, '0, 1'b1, 16'd2); tick(); check_pair("skew_p1", 16'd20, 16'd2);
    drive(1'b0, '0, 1'b1, 16'd3); tick(); check_pair("skew_p2", 16'd30, 16'd3);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("skew_end_r", 32'(R_OUT1), 32'd0);
    check("skew_end_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd0);

    // Overflow: five A tokens into a depth-4 side
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 1'b0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0);
    check("ovf_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd4);
    check("ovf_flag", 32'(OVF), 32'(OVF_AFTER_DROP));
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, '0, 1'b1, 16'(10 + i));
      tick();
      check_pair($sformatf("ovf_p%0d", i), 16'(i), 16'(10 + i));
    end
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("ovf_drain_r", 32'(R_OUT1), 32'd0);
    check("ovf_drain_cnt", 32'(dut.u_fifo_a.count_o), 32'd0);

    // Full side with simultaneous pop and push
    for (int i = 41; i <= 44; i++) begin
      drive(1'b1, 16'(i), 1'b0, '0);
      tick();
    end
    check("full_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd4);
    drive(1'b1, 16'd99, 1'b1, 16'd5);
    tick();
    check_pair("full_pop", 16'd41, 16'd5);
    check("full_pop_cnt", 32'(dut.u_fifo_a.count_o), 32'd4);
    check("full_pop_ovf", 32'(OVF), 32'(OVF_AFTER_DROP));
    drive(1'b0, '0, 1'b1, 16'd6); tick(); check_pair("full_d0", 16'd42, 16'd6);
    drive(1'b0, '0, 1'b1, 16'd7); tick(); check_pair("full_d1", 16'd43, 16'd7);
    drive(1'b0, '0, 1'b1, 16'd8); tick(); check_pair("full_d2", 16'd44, 16'd8);
    drive(1'b0, '0, 1'b1, 16'd9); tick(); check_pair("full_d3", 16'd99, 16'd9);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("full_end_cnt", 32'(dut.u_fifo_a.count_o), 32'd0);

    // EN low freezes everything, including a high R_OUT
    drive(1'b1, 16'd50, 1'b1, 16'd60);
    tick();
    check_pair("en_pre", 16'd50, 16'd60);
    EN = 1'b0;
    drive(1'b1, 16'd70, 1'b1, 16'd80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pair($sformatf("en_hold%0d", i), 16'd50, 16'd60);
      check($sformatf("en_cnt_a%0d", i), 32'(dut.u_fifo_a.count_o), 32'd0);
      check($sformatf("en_cnt_b%0d", i), 32'(dut.u_fifo_b.count_o), 32'd0);
    end
    EN = 1'b1;
    drive(1'b1, 16'd71, 1'b1, 16'd81);
    tick();
    check_pair("en_resume", 16'd71, 16'd81);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    check("en_resume_idle", 32'(R_OUT1), 32'd0);

    // Reset mid-stream with two A tokens buffered and R_OUT high
    drive(1'b1, 16'd31, 1'b0, '0); tick();
    drive(1'b1, 16'd32, 1'b0, '0); tick();
    drive(1'b1, 16'd33, 1'b1, 16'd300);
    tick();
    check_pair("mid_pre", 16'd31, 16'd300);
    check("mid_pre_cnt", 32'(dut.u_fifo_a.count_o), 32'd2);
    drive(1'b0, '0, 1'b0, '0);
    #1;
    RST = 1'b1;
    #1;
    check("mid_rst_r1", 32'(R_OUT1), 32'd0);
    check("mid_rst_d1", 32'(D_OUT1), 32'd0);
    check("mid_rst_d2", 32'(D_OUT2), 32'd0);
    check("mid_rst_cnt", 32'(dut.u_fifo_a.count_o), 32'd0);
    check("mid_rst_ovf", 32'(OVF), 32'd0);
    tick();
    RST = 1'b0;
    drive(1'b0, '0, 1'b1, 16'd400);
    tick();
    check("mid_b_only_r", 32'(R_OUT1), 32'd0);
    check("mid_b_only_cnt_b", 32'(dut.u_fifo_b.count_o), 32'd1);
    check("mid_b_only_cnt_a", 32'(dut.u_fifo_a.count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_join.md
# operand_join

Two-input token alignment stage that sits directly upstream of the binary dataflow operators (divide, multiply, subtract). It accepts operand tokens on two independent valid-qualified streams, buffers whichever side arrives early, and emits a matched operand pair with both output valids asserted in the same cycle. This lets the downstream operator, which only fires when both operand valids are high together, consume skewed streams without losing tokens.

## Interface
- N, 16, operand data width
- DEPTH, 4, per-side buffer depth in tokens; power of two, at least 2
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- EN  in  1  global stage enable; when low, all state freezes
- R_IN1  in  1  operand A token valid
- D_IN1  in  N  operand A data
- R_IN2  in  1  operand B token valid
- D_IN2  in  N  operand B data
- R_OUT1  out  1  paired operand A valid
- D_OUT1  out  N  paired operand A data
- R_OUT2  out  1  paired operand B valid; always equal to R_OUT1
- D_OUT2  out  N  paired operand B data
- OVF  out  1  sticky overflow flag (see Configuration)

## Operation
- Each side has a FIFO of DEPTH entries: read pointer, write pointer, and occupancy count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- A side is available when its count > 0 or its R_IN is high. The head of a side is the FIFO head if count > 0; otherwise it is the incoming D_IN.
- Fire condition, evaluated each edge with EN=1: both sides available.
- On fire: R_OUT1/R_OUT2 are set to 1 and D_OUT1/D_OUT2 are loaded from the heads. A non-empty FIFO pops. An incoming token that did not serve as the head is pushed.
- On no fire: R_OUT1/R_OUT2 are set to 0 and D_OUT holds. Each incoming token is pushed.
- Push with count==DEPTH and no pop on that side: the token is dropped, pointers and count are unchanged, and the overflow event fires.
- Simultaneous push and pop on one side: the count is unchanged and both pointers advance.
- EN=0: no push, no pop, and all outputs hold their values, including R_OUT. Incoming tokens are ignored.
- Token order is strictly FIFO per side. Pairing is by arrival index: the k-th A token pairs with the k-th B token.

## Timing
- Reset (asynchronous, immediate): R_OUT1=R_OUT2=0, D_OUT1=D_OUT2=0, OVF=0, all pointers and counts 0.
- Latency: a pair completed by inputs in cycle t appears on the outputs after edge t, which is 1 cycle. This matches the single-cycle operators downstream.
- Throughput: one pair per cycle when both streams are sustained.
- Reset asserted mid-stream discards all buffered tokens. The first edge after deassertion treats the FIFOs as empty.
- Deassertion of reset is synchronised externally; the block does not resynchronise it.

## Configuration
- JOIN_OVF_FLAG_EN defined: OVF is a sticky register. It is set on any drop on either side and cleared only by RST.
- JOIN_OVF_FLAG_EN undefined: OVF is tied to 0, the overflow logic is removed, and full-side drops still occur silently.

## Structure
- Shared package dataflow_pkg holds:
  - the default width constant (16)
  - the default join depth constant (4)
  - a function computing the count width from DEPTH
- Sub-module join_fifo:
  - single-stream FIFO with push, pop, head, count and full/empty outputs
  - instantiated once per side
  - top level holds only the fire, bypass and overflow logic plus the output registers.

## Test plan
- Aligned streams: R_IN1=R_IN2=1 with A=100, B=7 for one cycle. Required: one cycle later R_OUT1=R_OUT2=1, D_OUT1=100, D_OUT2=7; the next cycle R_OUT=0. No FIFO occupancy.
- Skew: A tokens 10, 20, 30 in cycles 0–2, then B tokens 1, 2, 3 in cycles 5–7. Required: pairs (10,1), (20,2), (30,3) emitted after edges 5, 6 and 7, in that order.
- Overflow: 5 A tokens (1..5) with DEPTH=4 and no B. Required: token 5 dropped and OVF=1 with the macro, OVF=0 without it. Then 4 B tokens produce pairs with A=1..4.
- Full plus simultaneous pop: A FIFO full (count 4). A B token and a new A token (99) arrive in the same cycle. Required: pair emitted with the old A head, 99 accepted, count stays 4, OVF unchanged.
- EN=0: assert EN=0 with tokens on both inputs for 3 cycles. Required: outputs and counts hold and inputs are ignored. Then EN=1 with one pair, which is emitted normally.
- Reset mid-stream: RST asserted with 2 A tokens buffered and R_OUT=1. Required: outputs 0 immediately. After release, a single B token does not fire.
